// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the SRAM port arbiter.
// Response-owner encoding and the default fetch starvation limit.
package sram_port_arbiter_pkg;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_INST = 2'd1,
      RSP_DATA = 2'd2
   } rsp_state_e;

   // Bits needed to count 0..limit inclusive
   function automatic int unsigned streak_w(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while fetch waits; flags when fetch
// must be forced through.
module arb_starve_ctr
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic inst_req,
   input  logic inst_gnt,
   input  logic data_gnt,
   output logic force_inst_c
);

   localparam int unsigned SW = streak_w(STARVE_LIMIT);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [SW-1:0] streak;

   // Saturating streak; any fetch grant or idle fetch clears it
   always_ff @(posedge clk) begin
      if (!rstn) begin
         streak <= '0;
      end else if (inst_gnt || !inst_req) begin
         streak <= '0;
      end else if (data_gnt && (streak != LIMIT)) begin
         streak <= streak + SW'(1);
      end
   end

   assign force_inst_c = (streak == LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and memory stages, data first with
// a fetch starvation guard. Optional perf counters: ARB_PERF_CNT_EN.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              inst_flush,
   input  logic              data_req,
   input  logic [3:0]        data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_conflict_cnt,
   output logic [31:0]       perf_starve_cnt
`endif
);

   logic       force_inst_c;
   logic       inst_win_c;
   rsp_state_e rsp_state;
   logic       flush_pend;

   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk          (clk),
      .rstn         (rstn),
      .inst_req     (inst_req),
      .inst_gnt     (inst_gnt),
      .data_gnt     (data_gnt),
      .force_inst_c (force_inst_c)
   );

   // Fetch wins only when alone or when data has starved it long enough
   assign inst_win_c = inst_req && (!data_req || force_inst_c);
   assign inst_gnt   = rstn && inst_win_c;
   assign data_gnt   = rstn && data_req && !inst_win_c;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 4'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (inst_gnt) begin
         mem_en   = 1'b1;
         mem_addr = inst_addr;
      end else if (data_gnt) begin
         mem_en    = 1'b1;
         mem_we    = data_we;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end
   end

   // Owner of next cycle's mem_rdata; writes return nothing
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rsp_state  <= RSP_IDLE;
         flush_pend <= 1'b0;
      end else begin
         if (inst_gnt) begin
            rsp_state <= RSP_INST;
         end else if (data_gnt && (data_we == 4'b0)) begin
            rsp_state <= RSP_DATA;
         end else begin
            rsp_state <= RSP_IDLE;
         end
         flush_pend <= inst_gnt && inst_flush;
      end
   end

   // A redirect in either the grant or the response cycle kills the fetch data
   assign inst_rvalid = rstn && (rsp_state == RSP_INST) && !flush_pend && !inst_flush;
   assign data_rvalid = rstn && (rsp_state == RSP_DATA);
   assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
   assign data_rdata  = data_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_conflict_cnt <= '0;
         perf_starve_cnt   <= '0;
      end else begin
         if (inst_req && data_req) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
         if (inst_gnt && data_req) begin
            perf_starve_cnt <= perf_starve_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed cycles push expected grants
// and responses; a negedge monitor pops and compares.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        inst_req, inst_gnt, inst_rvalid, inst_flush;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_gnt, data_rvalid;
   logic [3:0]  data_we;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_conflict_cnt, perf_starve_cnt;
`endif

   sram_port_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_gnt    (inst_gnt),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .inst_flush  (inst_flush),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_conflict_cnt (perf_conflict_cnt),
      .perf_starve_cnt   (perf_starve_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      byte         g;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gexp_t;

   typedef struct {
      int          cyc;
      byte         k;
      logic [31:0] d;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   int    cnum = 0;
   int    nvec = 0;
   int    nerr = 0;

   always @(posedge clk) cnum <= cnum + 1;

   // One cycle of stimulus; g/rk are 'N','I','D' for grant and next-cycle response
   task automatic step(input bit rst, input bit ir, input logic [31:0] ia, input bit fl,
                       input bit dr, input logic [3:0] we, input logic [31:0] da,
                       input logic [31:0] wd, input logic [31:0] mr, input byte g,
                       input byte rk, input logic [31:0] rd);
      rstn       = rst;
      inst_req   = ir;
      inst_addr  = ia;
      inst_flush = fl;
      data_req   = dr;
      data_we    = we;
      data_addr  = da;
      data_wdata = wd;
      mem_rdata  = mr;
      if (g == "I") gq.push_back('{cnum, g, 4'b0, ia, 32'h0});
      else if (g == "D") gq.push_back('{cnum, g, we, da, wd});
      else gq.push_back('{cnum, g, 4'b0, 32'h0, 32'h0});
      if (rk != "N") rq.push_back('{cnum + 1, rk, rd});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [31:0] mr);
      step(1, 0, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, mr, "N", "N", 32'h0);
   endtask

   // Monitor: compares grants, mem mux and responses against the queues
   initial begin
      gexp_t ge;
      rexp_t re;
      byte   ag, ak;
      logic [31:0] ad;
      forever begin
         @(negedge clk);
         if (gq.size() > 0 && gq[0].cyc == cnum) begin
            ge = gq.pop_front();
            ag = (inst_gnt && data_gnt) ? "B" : inst_gnt ? "I" : data_gnt ? "D" : "N";
            nvec++;
            if (ag != ge.g || mem_en != (ge.g != "N")) begin
               nerr++;
               $display("FAIL grant cyc %0d: got gnt %c mem_en %b, required %c", cnum, ag, mem_en, ge.g);
            end
            if (ge.g != "N") begin
               nvec++;
               if (mem_we != ge.we || mem_addr != ge.addr || mem_wdata != ge.wdata) begin
                  nerr++;
                  $display("FAIL mem_mux cyc %0d: got we %b addr %h wdata %h, required we %b addr %h wdata %h",
                           cnum, mem_we, mem_addr, mem_wdata, ge.we, ge.addr, ge.wdata);
               end
            end
         end
         if (inst_rvalid || data_rvalid) begin
            ak = (inst_rvalid && data_rvalid) ? "B" : inst_rvalid ? "I" : "D";
            ad = inst_rvalid ? inst_rdata : data_rdata;
            nvec++;
            if (rq.size() == 0 || rq[0].cyc > cnum) begin
               nerr++;
               $display("FAIL rsp_unexpected cyc %0d: got %c data %h, required no response", cnum, ak, ad);
            end else begin
               re = rq.pop_front();
               if (ak != re.k || ad != re.d) begin
                  nerr++;
                  $display("FAIL rsp cyc %0d: got %c data %h, required %c data %h", cnum, ak, ad, re.k, re.d);
               end
            end
         end else begin
            nvec++;
            if (inst_rdata != 32'h0 || data_rdata != 32'h0) begin
               nerr++;
               $display("FAIL rdata_idle cyc %0d: got inst %h data %h, required 0", cnum, inst_rdata, data_rdata);
            end
            if (rq.size() > 0 && rq[0].cyc <= cnum) begin
               re = rq.pop_front();
               nvec++;
               nerr++;
               $display("FAIL rsp_missing cyc %0d: got none, required %c data %h", cnum, re.k, re.d);
            end
         end
      end
   end

   initial begin
      int          dn;
      logic [31:0] ia;
      logic [3:0]  we;
      bit          ig;
      byte         rk;
      rstn = 1'b0; inst_req = 1'b0; inst_addr = '0; inst_flush = 1'b0;
      data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
      @(posedge clk);
      #1;
      // Reset with both requests high: nothing granted
      step(0, 1, 32'h1c000000, 0, 1, 4'b0, 32'h40, 32'h0, 32'h0, "N", "N", 32'h0);
      step(0, 0, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, "N", "N", 32'h0);
      // Fetch only
      step(1, 1, 32'h1c000000, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, "I", "I", 32'hDEADBEEF);
      idle(32'hDEADBEEF);
      // Data read only
      step(1, 0, 32'h0, 0, 1, 4'b0, 32'h40, 32'h0, 32'h0, "D", "D", 32'h00001234);
      idle(32'h00001234);
      // Both held: D D D D I then streak restarts, D D D D I
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         ig = (k == 4 || k == 9);
         ia = (k <= 4) ? 32'h1c000004 : 32'h1c000008;
         we = (dn == 3) ? 4'b1111 : 4'b0000;
         rk = ig ? "I" : (we != 4'b0) ? "N" : "D";
         step(1, 1, ia, 0, 1, we, 32'h1000 + 32'(dn * 4), 32'hA5A50000 + 32'(dn),
              32'h50000000 + 32'(k), ig ? "I" : "D", rk, 32'h50000000 + 32'(k + 1));
         if (!ig) dn++;
      end
      idle(32'h5000000A);
      // Flush in the response cycle
      step(1, 1, 32'h1c000010, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, "I", "N", 32'h0);
      step(1, 0, 32'h0, 1, 0, 4'b0, 32'h0, 32'h0, 32'h77, "N", "N", 32'h0);
      // Flush in the grant cycle: still granted, response dropped
      step(1, 1, 32'h1c000020, 1, 0, 4'b0, 32'h0, 32'h0, 32'h0, "I", "N", 32'h0);
      idle(32'h88);
      // Fetch right after: pending flush must be gone
      step(1, 1, 32'h1c000024, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, "I", "I", 32'h0BADF00D);
      idle(32'h0BADF00D);
      // Partial write: no response
      step(1, 0, 32'h0, 0, 1, 4'b0011, 32'h2000, 32'h12345678, 32'h0, "D", "N", 32'h0);
      idle(32'h99);
      // Read grant followed by reset: response dropped
      step(1, 0, 32'h0, 0, 1, 4'b0, 32'h3000, 32'h0, 32'h0, "D", "N", 32'h0);
      step(0, 1, 32'h1c000000, 0, 1, 4'b0, 32'h3000, 32'h0, 32'h66, "N", "N", 32'h0);
      step(1, 1, 32'h1c000000, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, "I", "I", 32'hDEADBEEF);
      idle(32'hDEADBEEF);
      idle(32'h0);
      @(negedge clk);
      while (rq.size() > 0) begin
         rexp_t re;
         re = rq.pop_front();
         nvec++;
         nerr++;
         $display("FAIL rsp_leftover: got none, required %c data %h", re.k, re.d);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between the Fetch/Memory stage SRAM outputs and the physical SRAM macro.
- Grants one request per cycle with data priority and a starvation guard for fetch.
- Routes the 1-cycle-latency read data back to the correct requester and discards squashed fetch responses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive data grants with fetch waiting before fetch is forced through.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- inst_req  in  1  fetch read request (the fetch stage's SRAM enable)
- inst_addr  in  ADDR_W  fetch address
- inst_gnt  out  1  fetch request accepted this cycle
- inst_rvalid  out  1  fetch read data valid
- inst_rdata  out  DATA_W  fetch read data
- inst_flush  in  1  branch redirect; squash any in-flight fetch response
- data_req  in  1  data request
- data_we  in  4  byte write enables; 0 = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_gnt  out  1  data request accepted
- data_rvalid  out  1  data read data valid
- data_rdata  out  DATA_W  data read data
- mem_en  out  1  SRAM enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Reset (rstn low at posedge):
  - state=IDLE, streak=0.
  - All *_rvalid and *_gnt are 0, mem_en=0.
  - Any outstanding response is dropped.
- Grant (combinational, same cycle as request):
  - Only data_req high -> data_gnt=1.
  - Only inst_req high -> inst_gnt=1.
  - Both high and streak<STARVE_LIMIT -> data_gnt=1.
  - Both high and streak==STARVE_LIMIT -> inst_gnt=1.
  - Never both gnt=1 in one cycle.
  - The mem_* outputs are muxed from the granted requester.
  - mem_en = inst_gnt | data_gnt.
  - For an inst grant, mem_we=0 and mem_wdata=0.
- Streak counter:
  - Increments (saturating at STARVE_LIMIT) on a data grant while inst_req=1.
  - Resets to 0 on an inst grant, or when inst_req=0.
- Response state register (next-cycle owner): IDLE, INST_RD, DATA_RD.
  - inst grant -> INST_RD.
  - data grant with we==0 -> DATA_RD.
  - data write or no grant -> IDLE.
- Response routing:
  - In INST_RD: inst_rvalid=!flush_pend, inst_rdata=mem_rdata.
  - In DATA_RD: data_rvalid=1, data_rdata=mem_rdata.
  - rdata buses read 0 when the matching rvalid is 0.
  - Writes produce no response; data_gnt is the only completion.
- Flush:
  - inst_flush high in the grant cycle, or in the INST_RD cycle -> that fetch response is suppressed (inst_rvalid=0).
  - flush_pend is a 1-bit register set when inst_flush coincides with an inst grant, cleared on the next cycle.
  - A fetch request presented in the same cycle as inst_flush is still granted normally; the requester presents the redirected address.
- Requesters must hold req/addr/wdata stable until gnt. Behaviour with unstable requests is not supported and not checked.
- Throughput: one access per cycle, back-to-back, no bubbles. Read latency is exactly 1 cycle from gnt to rvalid.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs perf_conflict_cnt[31:0] (cycles with both requests high) and perf_starve_cnt[31:0] (forced inst grants).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Shared header Defines.vh: response-state encodings (RSP_IDLE=2'd0, RSP_INST=2'd1, RSP_DATA=2'd2) and the default STARVE_LIMIT.
- One natural sub-module: arb_starve_ctr (saturating streak counter plus force-inst flag).
- The rest stays flat in sram_port_arbiter.

Test Plan:
- inst_req only, addr 0x1c000000, mem_rdata=0xDEADBEEF next cycle -> inst_gnt=1 in cycle 0, inst_rvalid=1 with rdata 0xDEADBEEF in cycle 1, data_rvalid=0.
- Both requesting, data read 0x1000 -> data_gnt=1, inst_gnt=0; data_rvalid=1 in the next cycle; inst still waiting.
- Both held high for 6 cycles with STARVE_LIMIT=4 -> grants D,D,D,D,I,D; streak returns to 0 after the I grant.
- inst granted, inst_flush=1 in the following cycle -> inst_rvalid stays 0 and data_rvalid stays 0.
- data write we=4'b0011, addr 0x2000, wdata 0x12345678 -> mem_en=1, mem_we=0011, mem_wdata=0x12345678 same cycle; no rvalid the next cycle.
- rstn=0 asserted in the cycle after a data read grant -> data_rvalid=0 and state=IDLE on the next edge; after release, the first inst grant behaves as in scenario 1.
